inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch front end for the RV_GO core. Holds the PC and drives word addresses to the instruction SRAM read port, whose data returns one cycle later. It tracks the in-flight read and buffers returned instructions in a 2-entry queue. It presents {pc, instr} to decode over a valid/ready handshake and flushes on branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.
- clk  in  1  core clock; SRAM read port shares it.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  word address to instruction SRAM read port.
  - Value is {2'b00, pc[31:2]}.
  - The SRAM uses the low 9 bits; higher bits alias.
- imem_rdata  in  32  SRAM read data; valid the cycle after the address is sampled.
- redirect_valid  in  1  flush-and-redirect request from execute.
- redirect_pc  in  32  redirect target byte address; bits [1:0] are ignored and treated as 0.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts this cycle.
- id_pc  out  32  byte PC of the presented instruction.
- id_instr  out  32  presented instruction word.

## Operation
- State:
  - pc_q: next sequential fetch PC.
  - inflight_q: flag plus inflight_pc_q.
  - 2-entry FIFO of {pc, instr}: count 0..2, head/tail pointers.
- pop = id_valid & id_ready.
- id_valid = (count != 0) & ~redirect_valid.
- id_pc/id_instr = head entry; a stale head value is allowed when count == 0.
- The SRAM reads every cycle. imem_rdata is used only when inflight_q == 1.
- Address mux (combinational):
  - redirect_valid = 1: imem_addr = redirect_pc word.
  - Otherwise: imem_addr = pc_q word.
- Issue rule, no redirect: issue = (count + inflight_q - pop) < 2.
  - On issue: inflight_q <= 1, inflight_pc_q <= pc_q, pc_q <= pc_q + 4.
  - On no issue: inflight_q <= 0, pc_q held.
- Response: when inflight_q == 1, push {inflight_pc_q, imem_rdata} into the FIFO at the end of the cycle.
- Simultaneous push and pop: count unchanged.
- The issue rule guarantees a push never overflows; overflow is an assertion failure.
- Redirect, which has priority over everything:
  - FIFO cleared (count <= 0).
  - The response arriving this cycle is discarded; no pop occurs.
  - The target is issued: inflight_q <= 1, inflight_pc_q <= target, pc_q <= target + 4.
- Back-to-back redirects: the later one wins; each kills the previous target's in-flight read.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset, asynchronous and immediate:
  - id_valid = 0, count = 0, inflight_q = 0.
  - pc_q = RESET_PC.
  - FIFO storage, id_pc and id_instr = 0.
  - imem_addr = RESET_PC >> 2.
- First cycle after rst_n rises (cycle 0): issue RESET_PC.
  - Cycle 1: data returns and is pushed.
  - Cycle 2: id_valid = 1 with id_pc = RESET_PC.
- Throughput is 1 instruction/cycle while id_ready = 1 (steady state count = 1, inflight = 1).
- Redirect asserted in cycle n gives id_valid with the target in cycle n+2. id_valid is 0 in cycles n and n+1.
- Backpressure: at most 2 buffered plus 1 in-flight instruction. Issue stops once the FIFO can no longer absorb the in-flight response. No instruction is lost or duplicated.
- Reset mid-operation discards all buffered and in-flight state.

## Test plan
- Reset/stream: RESET_PC = 0, mem[i] = 32'h1000_0000 + i, id_ready = 1.
  - id_valid first high 2 cycles after reset release: id_pc = 0, instr = 32'h1000_0000.
  - Then id_pc 4, 8, 12… every cycle with matching words.
- Backpressure: drop id_ready for 5 cycles mid-stream, then raise it.
  - FIFO holds exactly 2 entries; imem_addr is held.
  - After release, PCs continue contiguously with no gap or repeat.
- Redirect with full FIFO: redirect_valid = 1, redirect_pc = 32'h100 in cycle n while stalled.
  - id_valid = 0 in n and n+1.
  - Cycle n+2: id_pc = 32'h100, instr = mem[64]; then 32'h104…
  - No pre-redirect PC ever appears.
- Redirect colliding with pop and arriving response: redirect in the same cycle as id_ready = 1 and inflight = 1.
  - No handshake completes in that cycle.
  - The arriving word is discarded.
  - Back-to-back redirects to 32'h200 then 32'h300: only 32'h300 and successors appear.
- Misaligned target: redirect_pc = 32'h102 gives imem_addr = 32'h40 and id_pc = 32'h100.
- Async reset mid-stream: pull rst_n low between clock edges.
  - id_valid falls immediately.
  - After release, fetch restarts at RESET_PC with 2-cycle latency.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC register, one-deep in-flight SRAM read tracking,
// and a 2-entry {pc, instr} queue handed to decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;
  logic [31:0] target;

  always_comb begin
    target    = {redirect_pc[31:2], 2'b00};
    id_valid  = (count_q != 2'd0) & ~redirect_valid;
    pop       = id_valid & id_ready;
    // A redirect kills the response arriving this cycle.
    push      = inflight_q & ~redirect_valid;
    // Slots committed after this cycle: buffered + in-flight - popped.
    occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = occ < 3'd2;
    imem_addr = redirect_valid ? {2'b00, redirect_pc[31:2]} : {2'b00, pc_q[31:2]};
    id_pc     = fifo_pc_q[head_q];
    id_instr  = fifo_instr_q[head_q];
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    if (redirect_valid) begin
      count_d       = 2'd0;
      head_d        = 1'b0;
      tail_d        = 1'b0;
      inflight_d    = 1'b1;
      inflight_pc_d = target;
      pc_d          = target + 32'd4;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end else begin
        inflight_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= 32'h0;
        fifo_instr_q[i] <= 32'h0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      if (push) begin
        fifo_pc_q[tail_q]    <= inflight_pc_q;
        fifo_instr_q[tail_q] <= imem_rdata;
      end
    end
  end

  // The issue rule must keep the queue from ever overflowing.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and random checks of inst_fetch against a stream-level model:
// delivered PCs are contiguous from the last reset/redirect target, 2-cycle restart latency.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [512];
  logic [31:0] exp_pc;  // PC the next delivered instruction must carry
  int          since;   // cycles since last reset release / redirect, saturating at 2

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM, 512 words, upper address bits alias.
  always @(posedge clk) imem_rdata <= mem[imem_addr[8:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] p);
    return 32'h1000_0000 + {23'h0, p[10:2]};
  endfunction

  // One cycle: drive inputs, check at negedge, update model, return at posedge+1.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_addr;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    tgt            = {rpc[31:2], 2'b00};
    @(negedge clk);
    exp_valid = !rv && (since >= 2);
    if (rv) exp_addr = {2'b00, rpc[31:2]};
    else begin
      exp_addr = exp_pc + 32'(4 * since);
      exp_addr = {2'b00, exp_addr[31:2]};
    end
    chk("id_valid", {31'h0, id_valid}, {31'h0, exp_valid});
    chk("imem_addr", imem_addr, exp_addr);
    if (id_valid && exp_valid) begin
      chk("id_pc", id_pc, exp_pc);
      chk("id_instr", id_instr, word_of(exp_pc));
    end
    if (rv) begin
      exp_pc = tgt;
      since  = 1;
    end else begin
      if (id_valid && rdy) exp_pc = exp_pc + 32'd4;
      if (since < 2) since++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + 32'(i);
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_pc = 32'h0;
    since  = 0;

    // Stream, then backpressure for 5 cycles and release.
    run(10, 1'b1);
    run(5, 1'b0);
    run(5, 1'b1);

    // Redirect while stalled with a full queue.
    run(3, 1'b0);
    step(1'b0, 1'b1, 32'h100);
    run(6, 1'b1);

    // Redirect colliding with pop and a returning response, then back-to-back.
    step(1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b1, 32'h300);
    run(6, 1'b1);

    // Misaligned target, then PC wrap past the top of the address space.
    step(1'b1, 1'b1, 32'h102);
    run(5, 1'b1);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    run(5, 1'b1);

    // Random ready and redirects.
    for (int i = 0; i < 300; i++) begin
      logic rv;
      rv = ($urandom_range(15) == 0);
      step(($urandom_range(3) != 0), rv, $urandom);
    end
    run(4, 1'b1);

    // Asynchronous reset between clock edges.
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'h0, id_valid}, 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_pc", id_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_pc = 32'h0;
    since  = 0;
    run(8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
